// File: rtl/frame_pkg.sv
// Shared parameters and state encoding for the frame-capture RAM reader.
package frame_pkg;

    localparam int LINES    = 176;
    localparam int COLUMNS  = 288;
    localparam int S_DATA   = 8;
    localparam int S_LINE   = 8;
    localparam int S_COLUMN = 9;
    localparam int S_SUM    = 24;

    localparam logic [S_LINE:0]   LINE_LIM = (S_LINE+1)'(LINES);
    localparam logic [S_COLUMN:0] COL_LIM  = (S_COLUMN+1)'(COLUMNS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADDR,
        LOAD,
        SEND,
        DONE
    } state_e;

    // One extra bit on each sum so an oversize window cannot wrap into range.
    function automatic logic win_reject(
        input logic [S_LINE-1:0]   line0,
        input logic [S_COLUMN-1:0] col0,
        input logic [S_LINE-1:0]   height,
        input logic [S_COLUMN-1:0] width
    );
        logic [S_LINE:0]   line_end;
        logic [S_COLUMN:0] col_end;
        line_end = {1'b0, line0} + {1'b0, height};
        col_end  = {1'b0, col0} + {1'b0, width};
        return (height == '0) || (width == '0) ||
               (line_end > LINE_LIM) || (col_end > COL_LIM);
    endfunction

endpackage

// File: rtl/window_scan_counter.sv
// Raster line/column counter over a window: column inner, line outer.
module window_scan_counter
    import frame_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                load_i,
    input  logic                advance_i,
    input  logic [S_LINE-1:0]   line0_i,
    input  logic [S_COLUMN-1:0] col0_i,
    input  logic [S_LINE-1:0]   height_i,
    input  logic [S_COLUMN-1:0] width_i,
    output logic [S_LINE-1:0]   line_o,
    output logic [S_COLUMN-1:0] col_o,
    output logic                at_last_o
);

    logic [S_LINE-1:0]   line_q;
    logic [S_COLUMN-1:0] col_q;
    logic [S_LINE-1:0]   last_line;
    logic [S_COLUMN-1:0] last_col;

    // Accepted windows end inside the frame, so these cannot overflow.
    assign last_line = line0_i + height_i - 1'b1;
    assign last_col  = col0_i + width_i - 1'b1;

    always_ff @(posedge clk) begin
        if (clear) begin
            line_q <= '0;
            col_q  <= '0;
        end else if (load_i) begin
            line_q <= line0_i;
            col_q  <= col0_i;
        end else if (advance_i) begin
            if (col_q == last_col) begin
                col_q  <= col0_i;
                line_q <= line_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign line_o    = line_q;
    assign col_o     = col_q;
    assign at_last_o = (line_q == last_line) && (col_q == last_col);

endmodule

// File: rtl/frame_window_reader.sv
// Scans a window of the frame RAM and streams bytes over valid/ready.
// FRAME_WINDOW_READER_ACCUM_EN adds a running byte sum on the sum port.
module frame_window_reader
    import frame_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                start,
    input  logic [S_LINE-1:0]   win_line0,
    input  logic [S_COLUMN-1:0] win_col0,
    input  logic [S_LINE-1:0]   win_height,
    input  logic [S_COLUMN-1:0] win_width,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [S_LINE-1:0]   ram_addr_line,
    output logic [S_COLUMN-1:0] ram_addr_column,
    input  logic [S_DATA-1:0]   ram_q,
    output logic [S_DATA-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef FRAME_WINDOW_READER_ACCUM_EN
    output logic [S_SUM-1:0]    sum,
`endif
    output logic                out_last
);

    state_e              state_q;
    logic [S_LINE-1:0]   line0_q;
    logic [S_COLUMN-1:0] col0_q;
    logic [S_LINE-1:0]   height_q;
    logic [S_COLUMN-1:0] width_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [S_DATA-1:0]   data_q;
    logic                valid_q;
    logic                last_q;
    logic                load_d;
    logic                adv_d;
    logic                at_last;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
    logic [S_SUM-1:0]    sum_q;
`endif

    assign load_d = (state_q == CHECK) && !err_q;
    assign adv_d  = (state_q == SEND) && out_ready && !last_q;

    window_scan_counter u_cnt (
        .clk       (clk),
        .clear     (clear),
        .load_i    (load_d),
        .advance_i (adv_d),
        .line0_i   (line0_q),
        .col0_i    (col0_q),
        .height_i  (height_q),
        .width_i   (width_q),
        .line_o    (ram_addr_line),
        .col_o     (ram_addr_column),
        .at_last_o (at_last)
    );

    // The reject verdict is taken at capture so err shows during CHECK.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            line0_q  <= '0;
            col0_q   <= '0;
            height_q <= '0;
            width_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
            sum_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        line0_q  <= win_line0;
                        col0_q   <= win_col0;
                        height_q <= win_height;
                        width_q  <= win_width;
                        err_q    <= win_reject(win_line0, win_col0,
                                               win_height, win_width);
                        busy_q   <= 1'b1;
                        state_q  <= CHECK;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
                        sum_q    <= '0;
`endif
                    end
                end
                CHECK: begin
                    err_q <= 1'b0;
                    if (err_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= ADDR;
                    end
                end
                ADDR: state_q <= LOAD;
                LOAD: begin
                    data_q  <= ram_q;
                    valid_q <= 1'b1;
                    last_q  <= at_last;
                    state_q <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
                        sum_q   <= sum_q + S_SUM'(data_q);
`endif
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
    assign sum       = sum_q;
`endif

endmodule

// File: tb/tb_frame_window_reader.sv
// Scoreboard bench for frame_window_reader with a registered-read RAM model.
module tb_frame_window_reader;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [7:0] win_line0;
    logic [8:0] win_col0;
    logic [7:0] win_height;
    logic [8:0] win_width;
    logic       busy, done, err;
    logic [7:0] ram_addr_line;
    logic [8:0] ram_addr_column;
    logic [7:0] ram_q = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
    logic [23:0] sum;
    logic [23:0] sum_done;
`endif

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [8:0] stall_v;
    bit         stall_f = 0;
    bit         ram_ff  = 0;

    int         first_v, n_done, n_err, n_valid, err_k;
    logic [7:0] a_line;
    logic [8:0] a_col;
    logic       busy2;

    always #5 clk = ~clk;

    frame_window_reader dut (
        .clk             (clk),
        .clear           (clear),
        .start           (start),
        .win_line0       (win_line0),
        .win_col0        (win_col0),
        .win_height      (win_height),
        .win_width       (win_width),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .ram_addr_line   (ram_addr_line),
        .ram_addr_column (ram_addr_column),
        .ram_q           (ram_q),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
`ifdef FRAME_WINDOW_READER_ACCUM_EN
        .sum             (sum),
`endif
        .out_last        (out_last)
    );

    // Registered-address RAM holding (line*16+col) mod 256, or all 0xFF.
    always @(posedge clk) begin
        if (ram_ff)
            ram_q <= 8'hFF;
        else
            ram_q <= 8'((int'(ram_addr_line) * 16
                        + int'(ram_addr_column)) % 256);
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall hold.
    always @(negedge clk) begin
        if (clear) begin
            stall_f = 0;
        end else begin
            if (stall_f)
                check("stall_hold", {out_valid, out_last, out_data},
                      {1'b1, stall_v});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %0h, expected none",
                             {out_last, out_data});
                end else begin
                    check("beat", {out_last, out_data}, exp_q.pop_front());
                end
                stall_f = 0;
            end else if (out_valid) begin
                stall_f = 1;
                stall_v = {out_last, out_data};
            end else begin
                stall_f = 0;
            end
        end
    end

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return 1'b0;
    endfunction

    task automatic run_scan(input logic [7:0] l0, input logic [8:0] c0,
                            input logic [7:0] h, input logic [8:0] w,
                            input int mode, input int limit);
        int k;
        bit fin;
        first_v = -1;
        n_done  = 0;
        n_err   = 0;
        n_valid = 0;
        err_k   = -1;
        busy2   = 1'bx;
        @(posedge clk);
        #1;
        win_line0  = l0;
        win_col0   = c0;
        win_height = h;
        win_width  = w;
        start      = 1'b1;
        out_ready  = rdy(mode, 0);
        k   = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (out_valid) begin
                n_valid++;
                if (first_v < 0) first_v = k;
            end
            if (done) begin
                n_done++;
`ifdef FRAME_WINDOW_READER_ACCUM_EN
                sum_done = sum;
`endif
            end
            if (err) begin
                n_err++;
                err_k = k;
            end
            if (k == 2) begin
                a_line = ram_addr_line;
                a_col  = ram_addr_column;
                busy2  = busy;
            end
            if (k >= 2 && !busy) begin
                fin = 1;
            end else if (k >= limit) begin
                tests++;
                fails++;
                $display("FAIL timeout: busy still %0b after %0d cycles",
                         busy, k);
                fin = 1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
            out_ready = rdy(mode, k);
        end
        out_ready = 1'b0;
    endtask

    task automatic push_2x3();
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h002);
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h112);
    endtask

    initial begin
        clear      = 1'b1;
        start      = 1'b0;
        win_line0  = '0;
        win_col0   = '0;
        win_height = '0;
        win_width  = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", {ram_addr_line, ram_addr_column}, 0);
`ifdef FRAME_WINDOW_READER_ACCUM_EN
        check("rst_sum", sum, 0);
`endif
        @(posedge clk);
        #1;
        clear = 1'b0;

        push_2x3();
        run_scan(8'd0, 9'd0, 8'd2, 9'd3, 0, 60);
        check("t1_first_valid", first_v, 4);
        check("t1_done", n_done, 1);
        check("t1_err", n_err, 0);
        check("t1_drained", exp_q.size(), 0);

        push_2x3();
        run_scan(8'd0, 9'd0, 8'd2, 9'd3, 1, 120);
        check("t2_done", n_done, 1);
        check("t2_err", n_err, 0);
        check("t2_drained", exp_q.size(), 0);

        run_scan(8'd175, 9'd0, 8'd2, 9'd1, 0, 20);
        check("t3_err", n_err, 1);
        check("t3_err_cycle", err_k, 1);
        check("t3_no_valid", n_valid, 0);
        check("t3_busy_c2", busy2, 0);
        check("t3_done", n_done, 0);

        run_scan(8'd0, 9'd0, 8'd1, 9'd0, 0, 20);
        check("t4_err", n_err, 1);
        check("t4_no_valid", n_valid, 0);

        exp_q.push_back(9'h10F);
        run_scan(8'd175, 9'd287, 8'd1, 9'd1, 0, 30);
        check("t5_addr_line", a_line, 175);
        check("t5_addr_col", a_col, 287);
        check("t5_first_valid", first_v, 4);
        check("t5_done", n_done, 1);
        check("t5_drained", exp_q.size(), 0);

        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        win_line0  = 8'd0;
        win_col0   = 9'd0;
        win_height = 8'd4;
        win_width  = 9'd4;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("t6_reach_send", out_valid, 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_last", out_last, 0);
        n_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("t6_no_done", n_done, 0);

        push_2x3();
        run_scan(8'd0, 9'd0, 8'd2, 9'd3, 0, 60);
        check("t7_first_valid", first_v, 4);
        check("t7_done", n_done, 1);
        check("t7_drained", exp_q.size(), 0);

`ifdef FRAME_WINDOW_READER_ACCUM_EN
        ram_ff = 1;
        for (int i = 0; i < 256; i++)
            exp_q.push_back({i == 255, 8'hFF});
        run_scan(8'd0, 9'd0, 8'd16, 9'd16, 0, 1000);
        check("t8_done", n_done, 1);
        check("t8_sum", sum_done, 24'd65280);
        check("t8_drained", exp_q.size(), 0);
        ram_ff = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
